// File: rtl/notas_scheduler.sv
// notas_scheduler: captures up to NSTUD student grades into a small buffer,
// then plays them back one at a time on SEG as a letter code (A/F/P), each
// grade held for DWELL clock cycles. LED shows {idx, count} by default.
//
// Optional feature: define NOTAS_STATS_EN to add saturating per-letter
// counters (nA, nF, nP) fed by accepted writes; in DONE, LED = {nA, nF}.
module notas_scheduler #(
    parameter int NSTUD     = 8,
    parameter int DWELL     = 4,
    parameter int NBITS_TOP = 8
) (
    input  logic                 clk_2,
    input  logic                 reset_n,
    input  logic [3:0]           nota_in,
    input  logic                 nota_valid,
    output logic                 nota_ready,
    input  logic                 start,
    input  logic                 clear,
    output logic [NBITS_TOP-1:0] SEG,
    output logic [NBITS_TOP-1:0] LED,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NSTUD);
    localparam int CNT_W = IDX_W + 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DW_W-1:0]      dwell_q, dwell_d;
    logic [NBITS_TOP-1:0] seg_d, led_d;
    logic                 busy_d;
    logic                 wr_en;
    logic [3:0]           grade_mem [NSTUD];

    // Letter code for one grade: 7..15 -> A, 4..6 -> F, 0..3 -> P.
    function automatic logic [7:0] letter_code(input logic [3:0] g);
        if (g >= 4'd7) return 8'h77;
        if (g >= 4'd4) return 8'h71;
        return 8'h73;
    endfunction

    // Count as shown on the 4-bit LED field; a full 16-entry buffer reads F.
    function automatic logic [3:0] led_count(input logic [CNT_W-1:0] c);
        if (32'(c) > 32'd15) return 4'hF;
        return 4'(c);
    endfunction

    // 4-bit counter increment that sticks at F instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        if (v == 4'hF) return v;
        return v + 4'd1;
    endfunction

`ifdef NOTAS_STATS_EN
    logic [3:0] na_q, nf_q, np_q;

    // Per-letter tallies of accepted writes, wiped by clear.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            na_q <= 4'd0;
            nf_q <= 4'd0;
            np_q <= 4'd0;
        end else if (clear) begin
            na_q <= 4'd0;
            nf_q <= 4'd0;
            np_q <= 4'd0;
        end else if (wr_en) begin
            if (nota_in >= 4'd7)      na_q <= sat_inc4(na_q);
            else if (nota_in >= 4'd4) nf_q <= sat_inc4(nf_q);
            else                      np_q <= sat_inc4(np_q);
        end
    end
`endif

    // Next state, counters and the values the output registers load.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        dwell_d    = dwell_q;
        wr_en      = 1'b0;
        nota_ready = (state_q == LOAD) && (count_q < CNT_W'(NSTUD));

        if (clear) begin
            state_d = LOAD;
            count_d = '0;
            idx_d   = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    // start beats a simultaneous write; an empty buffer ignores start
                    if (start && (count_q != '0)) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        dwell_d = '0;
                    end else if (nota_valid && nota_ready) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (dwell_q == DW_W'(DWELL - 1)) begin
                        dwell_d = '0;
                        if ((CNT_W'(idx_q) + CNT_W'(1)) < count_q) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        dwell_d = '0;
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end

        // Outputs are computed from the next state so they register in step with it
        seg_d = '0;
        if (state_d == SHOW) begin
            seg_d = NBITS_TOP'(letter_code(grade_mem[idx_d]));
        end
        busy_d     = (state_d == SHOW);
        led_d      = '0;
        led_d[7:4] = 4'(idx_d);
        led_d[3:0] = led_count(count_d);
`ifdef NOTAS_STATS_EN
        if (state_d == DONE) begin
            led_d[7:0] = {na_q, nf_q};
        end
`endif
    end

    // Control state and registered display outputs.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            count_q <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
            SEG     <= '0;
            LED     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            SEG     <= seg_d;
            LED     <= led_d;
            busy    <= busy_d;
        end
    end

    // Grade storage; contents survive clear and are simply overwritten.
    always_ff @(posedge clk_2) begin
        if (wr_en) begin
            grade_mem[count_q[IDX_W-1:0]] <= nota_in;
        end
    end

endmodule
